// File: rtl/fp_addsub_sched.sv
// Round-robin sequencer for the shared FP add/subtract datapath: it grants one of two
// requesters, holds the operands for EXEC_CYCLES cycles, then returns the registered result.
package fp_pkg;
  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_NAN  = 3'd1,
    ERR_INF  = 3'd2,
    ERR_OVF  = 3'd3,
    ERR_UNF  = 3'd4
  } o_err_t;
endpackage

module fp_addsub_sched
  import fp_pkg::*;
#(
  parameter int unsigned SIG_BITS    = 23,
  parameter int unsigned EXP_BITS    = 8,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic                             req0_op,
  input  logic [SIG_BITS+EXP_BITS:0]       req0_a,
  input  logic [SIG_BITS+EXP_BITS:0]       req0_b,
  input  logic                             req1_op,
  input  logic [SIG_BITS+EXP_BITS:0]       req1_a,
  input  logic [SIG_BITS+EXP_BITS:0]       req1_b,
  output logic [1:0]                       rsp_valid,
  input  logic [1:0]                       rsp_ready,
  output logic [SIG_BITS+EXP_BITS:0]       rsp_result,
  output o_err_t                           rsp_err,
  output logic                             au_opcode,
  output logic                             au_sign1,
  output logic [EXP_BITS-1:0]              au_exp1,
  output logic [SIG_BITS-1:0]              au_sig1,
  output logic                             au_sign2,
  output logic [EXP_BITS-1:0]              au_exp2,
  output logic [SIG_BITS-1:0]              au_sig2,
  input  logic [SIG_BITS+EXP_BITS:0]       au_fp_out,
  input  o_err_t                           au_err,
  output logic                             busy
);

  localparam int unsigned W     = SIG_BITS + EXP_BITS + 1;
  localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  o_err_t           err_q, err_d;

  logic [1:0]       gnt;
  logic             accept;
  logic             gnt_idx;

  always_comb begin
    gnt = '0;
    case (req_valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign gnt_idx   = req_ready[1];

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = gnt_idx ? req1_op : req0_op;
          a_d     = gnt_idx ? req1_a  : req0_a;
          b_d     = gnt_idx ? req1_b  : req0_b;
          owner_d = gnt_idx;
          cnt_d   = CNT_W'(EXEC_CYCLES - 1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          res_d   = au_fp_out;
          err_d   = au_err;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        // Only the owner's ready bit completes the response; the other bit is ignored.
        if (rsp_ready[owner_q]) begin
          prio_d  = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

  assign au_opcode = op_q;
  assign au_sign1  = a_q[W-1];
  assign au_exp1   = a_q[SIG_BITS +: EXP_BITS];
  assign au_sig1   = a_q[SIG_BITS-1:0];
  assign au_sign2  = b_q[W-1];
  assign au_exp2   = b_q[SIG_BITS +: EXP_BITS];
  assign au_sig2   = b_q[SIG_BITS-1:0];

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Bench for fp_addsub_sched: a behavioural datapath stand-in feeds au_fp_out/au_err and a
// scoreboard of expected responses is checked as each response appears.
module tb_fp_addsub_sched;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]  req_valid1, req_ready1, rsp_valid1, rsp_ready1;
  logic        req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] rsp_result, rsp_result1, au_fp_out, au_fp_out1;
  o_err_t      rsp_err, rsp_err1, au_err, au_err1;
  logic        au_opcode, au_sign1, au_sign2, busy;
  logic [7:0]  au_exp1, au_exp2;
  logic [22:0] au_sig1, au_sig2;
  logic        au_opcode1, au_sign1_1, au_sign2_1, busy1;
  logic [7:0]  au_exp1_1, au_exp2_1;
  logic [22:0] au_sig1_1, au_sig2_1;
  logic [64:0] au_all;

  fp_addsub_sched #(.SIG_BITS(23), .EXP_BITS(8), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err),
    .au_opcode(au_opcode), .au_sign1(au_sign1), .au_exp1(au_exp1), .au_sig1(au_sig1),
    .au_sign2(au_sign2), .au_exp2(au_exp2), .au_sig2(au_sig2),
    .au_fp_out(au_fp_out), .au_err(au_err), .busy(busy)
  );

  fp_addsub_sched #(.SIG_BITS(23), .EXP_BITS(8), .EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_result(rsp_result1), .rsp_err(rsp_err1),
    .au_opcode(au_opcode1), .au_sign1(au_sign1_1), .au_exp1(au_exp1_1), .au_sig1(au_sig1_1),
    .au_sign2(au_sign2_1), .au_exp2(au_exp2_1), .au_sig2(au_sig2_1),
    .au_fp_out(au_fp_out1), .au_err(au_err1), .busy(busy1)
  );

  // Stand-in for add_sub_top: knows only the operand combinations the bench issues.
  function automatic logic [31:0] dp_res(input logic op, input logic [31:0] a, input logic [31:0] b);
    case ({op, a, b})
      {1'b0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
      {1'b1, 32'h40400000, 32'h3F800000}: return 32'h40000000;
      {1'b0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {1'b1, 32'h40000000, 32'h3F800000}: return 32'h3F800000;
      {1'b0, 32'h7F800000, 32'h3F800000}: return 32'h7F800000;
      default:                            return 32'hDEADBEEF;
    endcase
  endfunction

  function automatic o_err_t dp_err(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'hFF || b[30:23] == 8'hFF) ? ERR_INF : ERR_NONE;
  endfunction

  always_comb begin
    au_fp_out  = dp_res(au_opcode, {au_sign1, au_exp1, au_sig1}, {au_sign2, au_exp2, au_sig2});
    au_err     = dp_err({au_sign1, au_exp1, au_sig1}, {au_sign2, au_exp2, au_sig2});
    au_fp_out1 = dp_res(au_opcode1, {au_sign1_1, au_exp1_1, au_sig1_1}, {au_sign2_1, au_exp2_1, au_sig2_1});
    au_err1    = dp_err({au_sign1_1, au_exp1_1, au_sig1_1}, {au_sign2_1, au_exp2_1, au_sig2_1});
    au_all     = {au_opcode, au_sign1, au_exp1, au_sig1, au_sign2, au_exp2, au_sig2};
  end

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] res;
    o_err_t      err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic set_req(input bit alt, input bit g, input logic op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input o_err_t err);
    if (g == 1'b0) begin req0_op = op; req0_a = a; req0_b = b; end
    else           begin req1_op = op; req1_a = a; req1_b = b; end
    if (alt) req_valid1[g] = 1'b1;
    else     req_valid[g]  = 1'b1;
    sb.push_back('{vld: (2'b01 << g), res: res, err: err});
  endtask

  task automatic wait_rsp(input bit alt, output int lat, output logic [1:0] seen);
    logic [1:0] v;
    lat  = 0;
    seen = '0;
    do begin
      @(negedge clk);
      lat++;
      v = alt ? rsp_valid1 : rsp_valid;
      seen |= v;
    end while (v == 2'b00 && lat < 20);
  endtask

  task automatic finish_rsp(input bit alt, input bit g);
    if (alt) rsp_ready1[g] = 1'b1;
    else     rsp_ready[g]  = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready  = '0;
    rsp_ready1 = '0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = '0; req_valid1 = '0; rsp_ready = '0; rsp_ready1 = '0;
    req0_op = 1'b0; req1_op = 1'b0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    #3;
    n_checks++; if (req_ready !== 2'b00) $display("FAIL rst_req_ready: got %b exp 00", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp_valid: got %b exp 00", rsp_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (rsp_result !== 32'h0) $display("FAIL rst_result: got %h exp 0", rsp_result); else n_pass++;
    n_checks++; if (rsp_err !== ERR_NONE) $display("FAIL rst_err: got %0d exp 0", rsp_err); else n_pass++;
    n_checks++; if (au_all !== 65'h0) $display("FAIL rst_au: got %h exp 0", au_all); else n_pass++;
    n_checks++; if ({busy1, rsp_valid1} !== 3'b000) $display("FAIL rst_dut1: got %b exp 000", {busy1, rsp_valid1}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_single_add;
    int lat; logic [1:0] seen; exp_t e;
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, ERR_NONE);
    #1;
    n_checks++; if (req_ready !== 2'b01) $display("FAIL add_grant: got %b exp 01", req_ready); else n_pass++;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL add_busy: got %b exp 1", busy); else n_pass++;
    wait_rsp(1'b0, lat, seen);
    e = sb.pop_front();
    n_checks++; if (lat != 3) $display("FAIL add_latency: got %0d exp 3", lat); else n_pass++;
    n_checks++; if (seen !== e.vld) $display("FAIL add_rsp_seen: got %b exp %b", seen, e.vld); else n_pass++;
    n_checks++; if (rsp_valid !== e.vld) $display("FAIL add_rsp_valid: got %b exp %b", rsp_valid, e.vld); else n_pass++;
    n_checks++; if (rsp_result !== e.res) $display("FAIL add_result: got %h exp %h", rsp_result, e.res); else n_pass++;
    n_checks++; if (rsp_err !== e.err) $display("FAIL add_err: got %0d exp %0d", rsp_err, e.err); else n_pass++;
    finish_rsp(1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if ({busy, rsp_valid} !== 3'b000) $display("FAIL add_done: got %b exp 000", {busy, rsp_valid}); else n_pass++;
  endtask

  task automatic test_single_sub;
    int lat = 0; exp_t e;
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, ERR_NONE);
    #1;
    n_checks++; if (req_ready !== 2'b10) $display("FAIL sub_grant: got %b exp 10", req_ready); else n_pass++;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (lat == 0 && rsp_valid != 2'b00) lat = i + 1;
      n_checks++;
      if (au_all !== {1'b1, 32'h40400000, 32'h3F800000})
        $display("FAIL sub_au_stable: cycle %0d got %h exp %h", i, au_all, {1'b1, 32'h40400000, 32'h3F800000});
      else n_pass++;
    end
    e = sb.pop_front();
    n_checks++; if (lat != 3) $display("FAIL sub_latency: got %0d exp 3", lat); else n_pass++;
    n_checks++; if (rsp_valid !== e.vld) $display("FAIL sub_rsp_valid: got %b exp %b", rsp_valid, e.vld); else n_pass++;
    n_checks++; if (rsp_result !== e.res) $display("FAIL sub_result: got %h exp %h", rsp_result, e.res); else n_pass++;
    n_checks++; if (rsp_err !== e.err) $display("FAIL sub_err: got %0d exp %0d", rsp_err, e.err); else n_pass++;
    finish_rsp(1'b0, 1'b1);
  endtask

  task automatic test_back_pressure;
    int lat; logic [1:0] seen; exp_t e;
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, ERR_NONE);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(1'b0, lat, seen);
    e = sb.pop_front();
    n_checks++; if (lat != 3) $display("FAIL bp_latency: got %0d exp 3", lat); else n_pass++;
    req1_op = 1'b1; req1_a = 32'h40000000; req1_b = 32'h3F800000;
    req_valid[1] = 1'b1;
    rsp_ready    = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== e.vld) $display("FAIL bp_rsp_valid: cycle %0d got %b exp %b", i, rsp_valid, e.vld); else n_pass++;
      n_checks++; if (rsp_result !== e.res) $display("FAIL bp_result: cycle %0d got %h exp %h", i, rsp_result, e.res); else n_pass++;
      n_checks++; if (req_ready !== 2'b00) $display("FAIL bp_req_ready: cycle %0d got %b exp 00", i, req_ready); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL bp_busy: cycle %0d got %b exp 1", i, busy); else n_pass++;
    end
    rsp_ready = 2'b01;
    @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL bp_release_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (req_ready !== 2'b10) $display("FAIL bp_release_grant: got %b exp 10", req_ready); else n_pass++;
    req_valid = '0;
    rsp_ready = '0;
  endtask

  task automatic test_reset_mid;
    int lat; logic [1:0] seen;
    @(negedge clk);
    req0_op = 1'b0; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({busy, rsp_valid, req_ready} !== 5'b0) $display("FAIL mid_rst_ctrl: got %b exp 00000", {busy, rsp_valid, req_ready}); else n_pass++;
    n_checks++; if (rsp_result !== 32'h0) $display("FAIL mid_rst_result: got %h exp 0", rsp_result); else n_pass++;
    n_checks++; if (rsp_err !== ERR_NONE) $display("FAIL mid_rst_err: got %0d exp 0", rsp_err); else n_pass++;
    n_checks++; if (au_all !== 65'h0) $display("FAIL mid_rst_au: got %h exp 0", au_all); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_rsp(1'b0, lat, seen);
    n_checks++; if (seen !== 2'b00) $display("FAIL mid_rst_no_rsp: got %b exp 00", seen); else n_pass++;
  endtask

  task automatic test_simultaneous;
    int lat; logic [1:0] seen; exp_t e;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      set_req(1'b0, 1'b0, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, ERR_NONE);
      set_req(1'b0, 1'b1, 1'b1, 32'h40000000, 32'h3F800000, 32'h3F800000, ERR_NONE);
      #1;
      n_checks++; if (req_ready !== 2'b01) $display("FAIL sim_first_grant: round %0d got %b exp 01", r, req_ready); else n_pass++;
      for (int k = 0; k < 2; k++) begin
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        wait_rsp(1'b0, lat, seen);
        e = sb.pop_front();
        n_checks++; if (lat != 3) $display("FAIL sim_latency: round %0d req %0d got %0d exp 3", r, k, lat); else n_pass++;
        n_checks++; if (rsp_valid !== e.vld) $display("FAIL sim_owner: round %0d got %b exp %b", r, rsp_valid, e.vld); else n_pass++;
        n_checks++; if (rsp_result !== e.res) $display("FAIL sim_result: round %0d got %h exp %h", r, rsp_result, e.res); else n_pass++;
        finish_rsp(1'b0, k[0]);
        if (k == 0) begin
          @(negedge clk);
          #1;
          n_checks++; if (req_ready !== 2'b10) $display("FAIL sim_second_grant: round %0d got %b exp 10", r, req_ready); else n_pass++;
        end
      end
    end
  endtask

  task automatic test_err_ec1;
    int lat; logic [1:0] seen; exp_t e;
    @(negedge clk);
    set_req(1'b1, 1'b0, 1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, ERR_INF);
    #1;
    n_checks++; if (req_ready1 !== 2'b01) $display("FAIL ec1_grant: got %b exp 01", req_ready1); else n_pass++;
    @(posedge clk);
    #1 req_valid1[0] = 1'b0;
    wait_rsp(1'b1, lat, seen);
    e = sb.pop_front();
    n_checks++; if (lat != 2) $display("FAIL ec1_latency: got %0d exp 2", lat); else n_pass++;
    n_checks++; if (rsp_valid1 !== e.vld) $display("FAIL ec1_rsp_valid: got %b exp %b", rsp_valid1, e.vld); else n_pass++;
    n_checks++; if (rsp_result1 !== e.res) $display("FAIL ec1_result: got %h exp %h", rsp_result1, e.res); else n_pass++;
    n_checks++; if (rsp_err1 !== e.err) $display("FAIL ec1_err: got %0d exp %0d", rsp_err1, e.err); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL ec1_main_idle: got %b exp 0", busy); else n_pass++;
    finish_rsp(1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (busy1 !== 1'b0) $display("FAIL ec1_done: got %b exp 0", busy1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_single_sub();
    test_back_pressure();
    test_reset_mid();
    test_simultaneous();
    test_err_ec1();
    n_checks++; if (sb.size() != 0) $display("FAIL sb_drained: got %0d exp 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/fp_addsub_sched.md
# fp_addsub_sched

Sequencing and arbitration controller for the shared single-precision FP add/subtract datapath, `add_sub_top`. Two requesters share the datapath, for example the FP issue stage and a load/convert helper. Each requester presents opcode and two packed IEEE-754 operands over a valid/ready handshake. The block grants one requester round-robin, holds the operands stable on the datapath inputs for a programmable settle time, registers the result and error code, and returns them to the owning requester over a second valid/ready handshake.

## Interface
- `SIG_BITS`, 23: significand field width; the operand width is `SIG_BITS+EXP_BITS+1`.
- `EXP_BITS`, 8: exponent field width.
- `EXEC_CYCLES`, 2: number of cycles the operands are held on the datapath before the result is sampled. Must be at least 1.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester request accept.
- `req0_op`, `req1_op`  in  1  opcode: 0 = add, 1 = subtract.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32  packed operands: sign in bit 31, exponent in [30:23], significand in [22:0].
- `rsp_valid`  out  2  per-requester response valid; one-hot or zero.
- `rsp_ready`  in  2  per-requester response accept.
- `rsp_result`  out  32  registered `fp_out`, shared by both requesters.
- `rsp_err`  out  `o_err_t` (fp_pkg)  registered error code, shared by both requesters.
- `au_opcode`, `au_sign1`, `au_exp1`, `au_sig1`, `au_sign2`, `au_exp2`, `au_sig2`  out  1/8/23 each  operand fields driven to `add_sub_top`.
- `au_fp_out`  in  32  datapath result.
- `au_err`  in  `o_err_t`  datapath error code.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and RESP. Reset enters IDLE.
- Round-robin pointer `prio`, 1 bit. Reset value is 0, meaning requester 0 wins.
- **IDLE:**
  - Grant goes to the valid requester. If both are valid, the grant goes to requester `prio`.
  - `req_ready` is the one-hot grant. It is asserted combinationally, only in IDLE.
  - On the handshake (`req_valid[g] & req_ready[g]`) the block:
    - captures the opcode and both operands into the operand registers;
    - sets `owner = g`;
    - loads `cnt = EXEC_CYCLES-1`;
    - moves to EXEC.
- **EXEC:**
  - The `au_*` outputs are driven from the operand registers and are stable for the whole state.
  - When `cnt == 0`: sample `au_fp_out` into `rsp_result` and `au_err` into `rsp_err`, then move to RESP.
  - Otherwise decrement `cnt`.
- **RESP:**
  - `rsp_valid[owner] = 1`; the other bit is 0.
  - `rsp_result` and `rsp_err` are held constant.
  - When `rsp_ready[owner]` is high:
    - set `prio = ~owner`;
    - return to IDLE.
  - `rsp_ready` on the non-owner bit is ignored.
- `au_*` field mapping: `sign = x[31]`, `exp = x[30:23]`, `sig = x[22:0]`, for `a` into operand 1 and `b` into operand 2.
- The operand registers are never modified outside the IDLE handshake, so `au_*` is stable from EXEC entry through RESP.
- Requesters must hold `req_valid` and the operands until `req_ready` is seen. Withdrawing a request before grant is legal and has no effect.
- At most one operation is in flight; there is no request buffering.
- `rsp_err` is passed through unmodified. The block does not interpret the error code.

## Timing
- Reset values:
  - `req_ready`, `rsp_valid`: 0.
  - `rsp_result`: 0.
  - `rsp_err`: 0.
  - `busy`: 0.
  - All `au_*`: 0.
  - `prio`: 0; `cnt`: 0; `owner`: 0.
- Accept handshake in cycle T:
  - EXEC occupies cycles T+1 through T+EXEC_CYCLES.
  - `rsp_valid` is high from cycle T+EXEC_CYCLES+1.
- With the default `EXEC_CYCLES` = 2, `rsp_valid` rises 3 cycles after the accept edge.
- Response handshake in cycle R: the block is in IDLE in R+1, and the earliest next accept is R+1.
- Minimum issue interval is `EXEC_CYCLES+2` cycles per operation.
- Simultaneous valid requests: only one is granted per IDLE visit. The loser keeps `req_valid` high and is granted on the next IDLE visit, because `prio` now favours it.
- Back-pressure in RESP: the FSM stays in RESP indefinitely. `req_ready` stays 0 and the result stays unchanged.
- `rst_n` asserted in any state: all registers clear immediately. Any in-flight result is discarded, no `rsp_valid` is produced, and the next accept follows from IDLE.
- `EXEC_CYCLES = 1`: EXEC lasts exactly one cycle and the sample happens on the exit edge.

## Test plan
- **Single add.** Requester 0: op=0, a=0x3F800000, b=0x40000000. Expect `rsp_valid[0]` exactly 3 cycles after accept, `rsp_result` = 0x40400000, `rsp_err` = 0, `rsp_valid[1]` = 0 throughout.
- **Single subtract.** Requester 1: op=1, a=0x40400000, b=0x3F800000. Expect `rsp_valid[1]`, `rsp_result` = 0x40000000, and `au_*` held stable for every cycle of EXEC and RESP.
- **Simultaneous requests after reset.** Both requesters valid: requester 0 (1.0+1.0) and requester 1 (2.0-1.0). Expect requester 0 served first with 0x40000000, then requester 1 with 0x3F800000. Repeat with both valid again and expect requester 0 granted after requester 1, i.e. alternation.
- **Back-pressure.** Hold `rsp_ready[0]` = 0 for 5 cycles in RESP. Expect `rsp_valid[0]` held high, `rsp_result` unchanged, `req_ready` = 0 even with `req_valid[1]` = 1, and `busy` = 1. Then release and expect return to IDLE the next cycle.
- **Reset mid-operation.** Pulse `rst_n` low during EXEC. Expect all outputs to reach their reset values asynchronously, no response ever produced for the aborted request, and `prio` = 0.
- **Error pass-through and `EXEC_CYCLES = 1`.** Drive a=0x7F800000 (+inf) and b=0x3F800000. Expect `rsp_err` equal to the `au_err` value sampled at EXEC exit, and latency of 2 cycles with `EXEC_CYCLES = 1`.
